// File: rtl/multi_output_port_pkg.sv
// Shared definitions for the multi-channel leaf output port.
// Holds the default field widths, the reserved-field width helper, the
// credit-update priority encoding and a saturation helper.
// Packet layout (MSB..LSB): valid(1) | dst_leaf | dst_port | reserved | addr | payload.
package multi_output_port_pkg;

  localparam int unsigned DFLT_NUM_CHANNELS  = 4;
  localparam int unsigned DFLT_CH_BITS       = 2;
  localparam int unsigned DFLT_PACKET_BITS   = 97;
  localparam int unsigned DFLT_LEAF_BITS     = 6;
  localparam int unsigned DFLT_PORT_BITS     = 4;
  localparam int unsigned DFLT_ADDR_BITS     = 7;
  localparam int unsigned DFLT_PAYLOAD_BITS  = 64;
  localparam int unsigned DFLT_BRAM_ADDR_BITS = 7;
  localparam int unsigned DFLT_FREESPACE_SIZE = 64;

  // Width of the zero-filled gap between dst_port and addr.
  function automatic int unsigned pkt_rsv_bits(input int unsigned pkt, input int unsigned leaf,
                                               input int unsigned port, input int unsigned addr,
                                               input int unsigned payload);
    return pkt - (1 + leaf + port + addr + payload);
  endfunction

  // Largest value an addr-wide credit counter may hold.
  function automatic logic [31:0] credit_max(input int unsigned addr_bits);
    return 32'((64'd1 << addr_bits) - 64'd1);
  endfunction

  function automatic logic [31:0] sat_limit(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

  typedef enum logic [2:0] {
    CR_HOLD,
    CR_LOAD,
    CR_ADD_POP,
    CR_ADD,
    CR_POP
  } credit_op_e;

  // First match wins.
  function automatic credit_op_e credit_op(input logic load, input logic add,
                                           input logic pop, input logic nonzero);
    if (load)        return CR_LOAD;
    if (add && pop)  return CR_ADD_POP;
    if (add)         return CR_ADD;
    if (pop && nonzero) return CR_POP;
    return CR_HOLD;
  endfunction

endpackage

// File: rtl/multi_output_port_if.sv
// User write streams and switch-side packet stream of the output port.
// master: user/switch side (drives payload, valids, grant).
// slave : the output port (drives accepts, packet, empty).
interface multi_output_port_if
  import multi_output_port_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DFLT_NUM_CHANNELS,
  parameter int unsigned PAYLOAD_BITS = DFLT_PAYLOAD_BITS,
  parameter int unsigned PACKET_BITS  = DFLT_PACKET_BITS
);
  logic [NUM_CHANNELS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_CHANNELS-1:0]              vld_user2b_out;
  logic [NUM_CHANNELS-1:0]              ack_b_out2user;
  logic                                 rd_en_sel;
  logic [PACKET_BITS-1:0]               internal_out;
  logic                                 empty;

  modport master (
    output din_leaf_user2interface, vld_user2b_out, rd_en_sel,
    input  ack_b_out2user, internal_out, empty
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2b_out, rd_en_sel,
    output ack_b_out2user, internal_out, empty
  );
endinterface

// File: rtl/output_port_channel.sv
// One channel of the output port: payload FIFO (sync read, registered data),
// credit counter, destination FIFO address counter and destination registers.
// Ports: write handshake (wr_*), pop/read data (rd_*), eligibility, config
// strobes already qualified by cfg_sel_i, sent_i (this channel's packet is
// valid this cycle), dst/addr outputs. Macro OUTPUT_PORT_PKT_CNT_EN adds a
// 32-bit sent-packet counter on pkt_cnt_o.
module output_port_channel
  import multi_output_port_pkg::*;
#(
  parameter int unsigned NUM_LEAF_BITS         = DFLT_LEAF_BITS,
  parameter int unsigned NUM_PORT_BITS         = DFLT_PORT_BITS,
  parameter int unsigned NUM_ADDR_BITS         = DFLT_ADDR_BITS,
  parameter int unsigned PAYLOAD_BITS          = DFLT_PAYLOAD_BITS,
  parameter int unsigned NUM_BRAM_ADDR_BITS    = DFLT_BRAM_ADDR_BITS,
  parameter int unsigned FREESPACE_UPDATE_SIZE = DFLT_FREESPACE_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PAYLOAD_BITS-1:0]  wr_data_i,
  input  logic                     wr_vld_i,
  output logic                     wr_ack_o,
  input  logic                     rd_en_i,
  output logic [PAYLOAD_BITS-1:0]  rd_data_o,
  output logic                     eligible_o,
  input  logic                     cfg_sel_i,
  input  logic                     cfg_dst_en_i,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf_i,
  input  logic [NUM_PORT_BITS-1:0] cfg_dst_port_i,
  input  logic                     update_freespace_en_i,
  input  logic [NUM_ADDR_BITS-1:0] freespace_i,
  input  logic                     update_fifo_addr_en_i,
  input  logic [NUM_ADDR_BITS-1:0] fifo_addr_i,
  input  logic                     add_freespace_en_i,
  input  logic                     sent_i,
  output logic [NUM_LEAF_BITS-1:0] dst_leaf_o,
  output logic [NUM_PORT_BITS-1:0] dst_port_o,
  output logic [NUM_ADDR_BITS-1:0] addr_o
`ifdef OUTPUT_PORT_PKT_CNT_EN
  ,
  output logic [31:0]              pkt_cnt_o
`endif
);
  localparam int unsigned DEPTH = 1 << NUM_BRAM_ADDR_BITS;
  localparam logic [31:0] CREDIT_MAX = credit_max(NUM_ADDR_BITS);
  localparam logic [NUM_BRAM_ADDR_BITS:0] CNT_FULL = (NUM_BRAM_ADDR_BITS+1)'(DEPTH);

  logic [PAYLOAD_BITS-1:0]       mem_q [DEPTH];
  logic [NUM_BRAM_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [NUM_BRAM_ADDR_BITS:0]   count_q;
  logic [PAYLOAD_BITS-1:0]       rd_data_q;
  logic [NUM_ADDR_BITS-1:0]      credit_q, credit_d, addr_q, addr_d;
  logic [NUM_LEAF_BITS-1:0]      leaf_q;
  logic [NUM_PORT_BITS-1:0]      port_q;
  logic [31:0]                   sum;
  logic                          full, fifo_empty, push, pop;

  assign full       = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  // Gated by reset so no accept is signalled while the port is held in reset.
  assign wr_ack_o   = wr_vld_i & ~full & rst_n;
  assign push       = wr_ack_o;
  assign pop        = rd_en_i & ~fifo_empty;
  assign eligible_o = ~fifo_empty & (credit_q != '0);
  assign rd_data_o  = rd_data_q;
  assign dst_leaf_o = leaf_q;
  assign dst_port_o = port_q;
  assign addr_o     = addr_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + NUM_BRAM_ADDR_BITS'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + NUM_BRAM_ADDR_BITS'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (NUM_BRAM_ADDR_BITS+1)'(1);
        2'b01:   count_q <= count_q - (NUM_BRAM_ADDR_BITS+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    credit_d = credit_q;
    sum      = '0;
    case (credit_op(cfg_sel_i & update_freespace_en_i, cfg_sel_i & add_freespace_en_i,
                    pop, credit_q != '0))
      CR_LOAD: credit_d = freespace_i;
      CR_ADD_POP: begin
        sum      = 32'(credit_q) + 32'(FREESPACE_UPDATE_SIZE) - 32'd1;
        credit_d = NUM_ADDR_BITS'(sat_limit(sum, CREDIT_MAX));
      end
      CR_ADD: begin
        sum      = 32'(credit_q) + 32'(FREESPACE_UPDATE_SIZE);
        credit_d = NUM_ADDR_BITS'(sat_limit(sum, CREDIT_MAX));
      end
      CR_POP:  credit_d = credit_q - NUM_ADDR_BITS'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (cfg_sel_i && update_fifo_addr_en_i) addr_d = fifo_addr_i;
    else if (sent_i)                        addr_d = addr_q + NUM_ADDR_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q <= '1;
      addr_q   <= '0;
      leaf_q   <= '0;
      port_q   <= '0;
    end else begin
      credit_q <= credit_d;
      addr_q   <= addr_d;
      if (cfg_sel_i && cfg_dst_en_i) begin
        leaf_q <= cfg_dst_leaf_i;
        port_q <= cfg_dst_port_i;
      end
    end
  end

`ifdef OUTPUT_PORT_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)      pkt_cnt_q <= '0;
    else if (sent_i) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end
  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: rtl/multi_output_port.sv
// Multi-channel leaf output port: merges NUM_CHANNELS user write streams into
// one packet stream toward the BFT switch. Round-robin arbitration over
// eligible channels (FIFO non-empty, credit > 0); packet emitted one cycle
// after the pop, all zeros otherwise.
// Ports: clk, rst_n (sync, active low), cfg_* / update_* / add_freespace_en
// config strobes targeting channel cfg_ch, bus (slave modport: payloads,
// valids, accepts, grant, packet, empty).
// Macro OUTPUT_PORT_PKT_CNT_EN adds per-channel sent counters and pkt_cnt.
module multi_output_port
  import multi_output_port_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS          = DFLT_NUM_CHANNELS,
  parameter int unsigned CH_BITS               = DFLT_CH_BITS,
  parameter int unsigned PACKET_BITS           = DFLT_PACKET_BITS,
  parameter int unsigned NUM_LEAF_BITS         = DFLT_LEAF_BITS,
  parameter int unsigned NUM_PORT_BITS         = DFLT_PORT_BITS,
  parameter int unsigned NUM_ADDR_BITS         = DFLT_ADDR_BITS,
  parameter int unsigned PAYLOAD_BITS          = DFLT_PAYLOAD_BITS,
  parameter int unsigned NUM_BRAM_ADDR_BITS    = DFLT_BRAM_ADDR_BITS,
  parameter int unsigned FREESPACE_UPDATE_SIZE = DFLT_FREESPACE_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_BITS-1:0]       cfg_ch,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
  input  logic                     cfg_dst_en,
  input  logic [NUM_ADDR_BITS-1:0] fifo_addr,
  input  logic [NUM_ADDR_BITS-1:0] freespace,
  input  logic                     update_freespace_en,
  input  logic                     update_fifo_addr_en,
  input  logic                     add_freespace_en,
  multi_output_port_if.slave       bus
`ifdef OUTPUT_PORT_PKT_CNT_EN
  ,
  output logic [31:0]              pkt_cnt
`endif
);
  localparam int unsigned RSV_BITS =
    pkt_rsv_bits(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS);

  logic [NUM_CHANNELS-1:0]  eligible, rd_en, sent, cfg_sel;
  logic [PAYLOAD_BITS-1:0]  rd_data  [NUM_CHANNELS];
  logic [NUM_LEAF_BITS-1:0] dst_leaf [NUM_CHANNELS];
  logic [NUM_PORT_BITS-1:0] dst_port [NUM_CHANNELS];
  logic [NUM_ADDR_BITS-1:0] addr     [NUM_CHANNELS];
`ifdef OUTPUT_PORT_PKT_CNT_EN
  logic [31:0]              ch_cnt   [NUM_CHANNELS];
`endif
  logic [CH_BITS-1:0]       rr_q, rr_d, gnt_idx, gnt_q, cand;
  logic                     gnt_vld, valid_q;
  logic [PACKET_BITS-1:0]   pkt;
  int unsigned              idx;

  assign bus.empty = ~|eligible;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign cfg_sel[i] = (32'(cfg_ch) == i);
    assign sent[i]    = valid_q && (32'(gnt_q) == i);

    output_port_channel #(
      .NUM_LEAF_BITS        (NUM_LEAF_BITS),
      .NUM_PORT_BITS        (NUM_PORT_BITS),
      .NUM_ADDR_BITS        (NUM_ADDR_BITS),
      .PAYLOAD_BITS         (PAYLOAD_BITS),
      .NUM_BRAM_ADDR_BITS   (NUM_BRAM_ADDR_BITS),
      .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
    ) u_ch (
      .clk                  (clk),
      .rst_n                (rst_n),
      .wr_data_i            (bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld_i             (bus.vld_user2b_out[i]),
      .wr_ack_o             (bus.ack_b_out2user[i]),
      .rd_en_i              (rd_en[i]),
      .rd_data_o            (rd_data[i]),
      .eligible_o           (eligible[i]),
      .cfg_sel_i            (cfg_sel[i]),
      .cfg_dst_en_i         (cfg_dst_en),
      .cfg_dst_leaf_i       (cfg_dst_leaf),
      .cfg_dst_port_i       (cfg_dst_port),
      .update_freespace_en_i(update_freespace_en),
      .freespace_i          (freespace),
      .update_fifo_addr_en_i(update_fifo_addr_en),
      .fifo_addr_i          (fifo_addr),
      .add_freespace_en_i   (add_freespace_en),
      .sent_i               (sent[i]),
      .dst_leaf_o           (dst_leaf[i]),
      .dst_port_o           (dst_port[i]),
      .addr_o               (addr[i])
`ifdef OUTPUT_PORT_PKT_CNT_EN
      ,
      .pkt_cnt_o            (ch_cnt[i])
`endif
    );
  end

  // Scan from the RR pointer upward with wrap; first eligible channel wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_d    = rr_q;
    rd_en   = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      idx  = (32'(rr_q) + i) % NUM_CHANNELS;
      cand = CH_BITS'(idx);
      if (!gnt_vld && bus.rd_en_sel && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) begin
      rd_en[gnt_idx] = 1'b1;
      rr_d = CH_BITS'((32'(gnt_idx) + 32'd1) % NUM_CHANNELS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= gnt_vld;
      rr_q    <= rr_d;
      if (gnt_vld) gnt_q <= gnt_idx;
    end
  end

  // Payload is already registered inside the channel FIFO; the packet is a
  // mux of registered state selected by the registered grant.
  if (RSV_BITS > 0) begin : g_rsv
    always_comb pkt = {1'b1, dst_leaf[gnt_q], dst_port[gnt_q], {RSV_BITS{1'b0}},
                       addr[gnt_q], rd_data[gnt_q]};
  end else begin : g_no_rsv
    always_comb pkt = {1'b1, dst_leaf[gnt_q], dst_port[gnt_q], addr[gnt_q], rd_data[gnt_q]};
  end

  assign bus.internal_out = valid_q ? pkt : '0;

`ifdef OUTPUT_PORT_PKT_CNT_EN
  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (32'(cfg_ch) == i) pkt_cnt = ch_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_multi_output_port.sv
// Directed bench for multi_output_port with default parameters.
module tb_multi_output_port;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_ch;
  logic [5:0] cfg_dst_leaf;
  logic [3:0] cfg_dst_port;
  logic       cfg_dst_en;
  logic [6:0] fifo_addr;
  logic [6:0] freespace;
  logic       update_freespace_en;
  logic       update_fifo_addr_en;
  logic       add_freespace_en;
`ifdef OUTPUT_PORT_PKT_CNT_EN
  logic [31:0] pkt_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  multi_output_port_if #(.NUM_CHANNELS(4), .PAYLOAD_BITS(64), .PACKET_BITS(97)) bus ();

  multi_output_port dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_ch             (cfg_ch),
    .cfg_dst_leaf       (cfg_dst_leaf),
    .cfg_dst_port       (cfg_dst_port),
    .cfg_dst_en         (cfg_dst_en),
    .fifo_addr          (fifo_addr),
    .freespace          (freespace),
    .update_freespace_en(update_freespace_en),
    .update_fifo_addr_en(update_fifo_addr_en),
    .add_freespace_en   (add_freespace_en),
    .bus                (bus)
`ifdef OUTPUT_PORT_PKT_CNT_EN
    ,
    .pkt_cnt            (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [96:0] exp_pkt(input logic [5:0] leaf, input logic [3:0] port,
                                          input logic [6:0] addr, input logic [63:0] pl);
    return {1'b1, leaf, port, 15'd0, addr, pl};
  endfunction

  function automatic logic [6:0] credit_of(input int ch);
    case (ch)
      0:       return dut.g_ch[0].u_ch.credit_q;
      1:       return dut.g_ch[1].u_ch.credit_q;
      2:       return dut.g_ch[2].u_ch.credit_q;
      default: return dut.g_ch[3].u_ch.credit_q;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_dst(input int ch, input logic [5:0] leaf, input logic [3:0] port);
    cfg_ch = 2'(ch); cfg_dst_leaf = leaf; cfg_dst_port = port; cfg_dst_en = 1'b1;
    step();
    cfg_dst_en = 1'b0;
  endtask

  task automatic set_din(input int ch, input logic [63:0] d);
    bus.din_leaf_user2interface[ch*64 +: 64] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cfg_ch = '0; cfg_dst_leaf = '0; cfg_dst_port = '0; cfg_dst_en = 1'b0;
    fifo_addr = '0; freespace = '0;
    update_freespace_en = 1'b0; update_fifo_addr_en = 1'b0; add_freespace_en = 1'b0;
    bus.din_leaf_user2interface = '0;
    bus.vld_user2b_out = 4'hF;
    bus.rd_en_sel = 1'b0;

    // Reset state
    step(); step();
    check("rst_ack", bus.ack_b_out2user, 4'h0);
    check("rst_out", bus.internal_out, '0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_credit0", credit_of(0), 7'd127);
    rst_n = 1'b1;
    bus.vld_user2b_out = '0;

    // Single packet on ch0
    set_dst(0, 6'd3, 4'd2);
    set_din(0, 64'hA5);
    bus.vld_user2b_out = 4'b0001;
    #1 check("t1_ack", bus.ack_b_out2user, 4'b0001);
    step();
    bus.vld_user2b_out = '0;
    check("t1_not_empty", bus.empty, 1'b0);
    bus.rd_en_sel = 1'b1;
    #1 check("t1_out_before", bus.internal_out, '0);
    step();
    bus.rd_en_sel = 1'b0;
    check("t1_pkt", bus.internal_out, exp_pkt(6'd3, 4'd2, 7'd0, 64'hA5));
    check("t1_credit", credit_of(0), 7'd126);
    step();
    check("t1_out_after", bus.internal_out, '0);
    check("t1_empty", bus.empty, 1'b1);

    // Round robin over four loaded channels
    do_reset();
    for (int ch = 0; ch < 4; ch++) set_dst(ch, 6'(10 + ch), 4'(ch + 1));
    for (int w = 0; w < 2; w++) begin
      for (int ch = 0; ch < 4; ch++) set_din(ch, 64'h1000 + 64'(ch * 16 + w));
      bus.vld_user2b_out = 4'hF;
      step();
    end
    bus.vld_user2b_out = '0;
    bus.rd_en_sel = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("t2_rr%0d", k), bus.internal_out,
            exp_pkt(6'(10 + k % 4), 4'(k % 4 + 1), 7'(k / 4), 64'h1000 + 64'((k % 4) * 16 + k / 4)));
    end
    check("t2_empty", bus.empty, 1'b1);
    bus.rd_en_sel = 1'b0;
    step();
    check("t2_idle", bus.internal_out, '0);

    // Zero credit on ch1 skips it; add restores it
    cfg_ch = 2'd1; freespace = 7'd0; update_freespace_en = 1'b1;
    step();
    update_freespace_en = 1'b0;
    for (int ch = 0; ch < 4; ch++) set_din(ch, 64'h3000 + 64'(ch));
    bus.vld_user2b_out = 4'hF;
    step();
    bus.vld_user2b_out = '0;
    bus.rd_en_sel = 1'b1;
    step();
    check("t3_ch0", bus.internal_out, exp_pkt(6'd10, 4'd1, 7'd2, 64'h3000));
    step();
    check("t3_ch2", bus.internal_out, exp_pkt(6'd12, 4'd3, 7'd2, 64'h3002));
    step();
    check("t3_ch3", bus.internal_out, exp_pkt(6'd13, 4'd4, 7'd2, 64'h3003));
    bus.rd_en_sel = 1'b0;
    check("t3_skip_empty", bus.empty, 1'b1);
    step();
    check("t3_idle", bus.internal_out, '0);
    cfg_ch = 2'd1; add_freespace_en = 1'b1;
    step();
    add_freespace_en = 1'b0;
    check("t3_credit_add", credit_of(1), 7'd64);
    check("t3_resume_empty", bus.empty, 1'b0);
    bus.rd_en_sel = 1'b1;
    step();
    bus.rd_en_sel = 1'b0;
    check("t3_ch1", bus.internal_out, exp_pkt(6'd11, 4'd2, 7'd2, 64'h3001));
    check("t3_credit_pop", credit_of(1), 7'd63);

    // Saturation and combined add+pop
    set_din(1, 64'h4001);
    bus.vld_user2b_out = 4'b0010;
    step();
    bus.vld_user2b_out = '0;
    cfg_ch = 2'd1; freespace = 7'd100; update_freespace_en = 1'b1;
    step();
    update_freespace_en = 1'b0;
    check("t4_load100", credit_of(1), 7'd100);
    add_freespace_en = 1'b1;
    step();
    add_freespace_en = 1'b0;
    check("t4_sat", credit_of(1), 7'd127);
    freespace = 7'd10; update_freespace_en = 1'b1;
    step();
    update_freespace_en = 1'b0;
    add_freespace_en = 1'b1; bus.rd_en_sel = 1'b1;
    step();
    add_freespace_en = 1'b0; bus.rd_en_sel = 1'b0;
    check("t4_addpop", credit_of(1), 7'd73);
    check("t4_pkt", bus.internal_out, exp_pkt(6'd11, 4'd2, 7'd3, 64'h4001));
    step();

    // Fill ch2, full backpressure, address wrap
    bus.vld_user2b_out = 4'b0100;
    for (int j = 0; j < 128; j++) begin
      set_din(2, 64'h5000 + 64'(j));
      step();
    end
    bus.vld_user2b_out = 4'hF;
    #1 check("t5_full_ack", bus.ack_b_out2user, 4'b1011);
    bus.vld_user2b_out = '0;
    cfg_ch = 2'd2; fifo_addr = 7'd125; update_fifo_addr_en = 1'b1;
    step();
    update_fifo_addr_en = 1'b0;
    set_din(2, 64'hDEAD);
    bus.vld_user2b_out = 4'b0100;
    bus.rd_en_sel = 1'b1;
    #1 check("t5_full_pushpop_ack", bus.ack_b_out2user, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      step();
      bus.vld_user2b_out = '0;
      check($sformatf("t5_addr%0d", k), bus.internal_out,
            exp_pkt(6'd12, 4'd3, 7'(125 + k), 64'h5000 + 64'(k)));
    end
    bus.rd_en_sel = 1'b0;
    check("t5_credit", credit_of(2), 7'd120);

    // Reset in the cycle after a pop
    bus.rd_en_sel = 1'b1;
    step();
    check("t6_pre_pkt", bus.internal_out, exp_pkt(6'd12, 4'd3, 7'd1, 64'h5004));
    rst_n = 1'b0;
    bus.vld_user2b_out = 4'hF;
    step();
    check("t6_out", bus.internal_out, '0);
    check("t6_empty", bus.empty, 1'b1);
    check("t6_ack", bus.ack_b_out2user, 4'h0);
    check("t6_credit2", credit_of(2), 7'd127);
    check("t6_credit1", credit_of(1), 7'd127);
    rst_n = 1'b1;
    bus.vld_user2b_out = '0;
    bus.rd_en_sel = 1'b0;
    step();
    check("t6_idle", bus.internal_out, '0);
    set_din(0, 64'h6000);
    bus.vld_user2b_out = 4'b0001;
    step();
    bus.vld_user2b_out = '0;
    bus.rd_en_sel = 1'b1;
    step();
    bus.rd_en_sel = 1'b0;
    check("t6_dst_reset", bus.internal_out, exp_pkt(6'd0, 4'd0, 7'd0, 64'h6000));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
